// File: rtl/ratio_fifo_if.sv
// Handshake bundle for ratio_fifo: wide word write side, narrow lane read side.
`ifndef ACCW
`define ACCW 8
`endif
`ifndef QDEPTH
`define QDEPTH 8
`endif

interface ratio_fifo_if #(
    parameter int ODW   = `ACCW,
    parameter int RATIO = 3,
    parameter int DEPTH = `QDEPTH
);
    localparam int IDW = RATIO * ODW;
    localparam int LW  = $clog2(RATIO + 1);
    localparam int UW  = $clog2(DEPTH * RATIO + 1);

    logic           wr_en;
    logic [IDW-1:0] wr_data;
    logic [LW-1:0]  wr_lanes;
    logic           wr_ok;
    logic           rd_en;
    logic [ODW-1:0] rd_data;
    logic           rd_ok;
    logic           rd_last;
    logic [UW-1:0]  usedw;

    modport master (
        output wr_en, wr_data, wr_lanes, rd_en,
        input  wr_ok, rd_data, rd_ok, rd_last, usedw
    );

    modport slave (
        input  wr_en, wr_data, wr_lanes, rd_en,
        output wr_ok, rd_data, rd_ok, rd_last, usedw
    );
endinterface

// File: rtl/ratio_fifo.sv
// Width-converting FIFO: stores RATIO-lane words, emits one ODW lane per pop.
// Optional macro RATIO_FIFO_PARTIAL_EN enables per-word valid-lane counts (wr_lanes).
`ifndef ACCW
`define ACCW 8
`endif
`ifndef QDEPTH
`define QDEPTH 8
`endif

module ratio_fifo #(
    parameter int ODW   = `ACCW,
    parameter int RATIO = 3,
    parameter int DEPTH = `QDEPTH,
    parameter int ID    = 0
) (
    input  logic          clk,
    input  logic          rst,
    ratio_fifo_if.slave   bus
);
    localparam int IDW = RATIO * ODW;
    localparam int LW  = $clog2(RATIO + 1);
    localparam int UW  = $clog2(DEPTH * RATIO + 1);
    localparam int AW  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW  = $clog2(DEPTH + 1);

    logic [IDW-1:0] mem [DEPTH];
    logic [AW-1:0]  wr_ptr_r, rd_ptr_r, wr_ptr_n_s, rd_ptr_n_s;
    logic [CW-1:0]  count_r, count_n_s;
    logic [LW-1:0]  lane_r, lane_n_s, wr_eff_s, nxt_lanes_s;
    logic [UW-1:0]  usedw_r, usedw_n_s;
    logic [ODW-1:0] rd_data_r, rd_data_n_s;
    logic [IDW-1:0] nxt_word_s;
    logic           wr_ok_r, rd_ok_r, rd_last_r;
    logic           do_wr_s, do_rd_s, retire_s;
    logic [31:0]    unused_id_s;

    assign unused_id_s = ID;

`ifdef RATIO_FIFO_PARTIAL_EN
    logic [LW-1:0] lanes_mem [DEPTH];

    function automatic logic [LW-1:0] eff_lanes(input logic [LW-1:0] l);
        if (l == {LW{1'b0}} || l > LW'(RATIO)) begin
            return LW'(RATIO);
        end else begin
            return l;
        end
    endfunction

    assign wr_eff_s = eff_lanes(bus.wr_lanes);

    // Per-entry valid-lane count store, normalised on write
    always_ff @(posedge clk) begin
        if (rst && do_wr_s) begin
            lanes_mem[wr_ptr_r] <= wr_eff_s;
        end
    end
`else
    logic unused_lanes_s;
    assign unused_lanes_s = ^bus.wr_lanes;
    assign wr_eff_s       = LW'(RATIO);
`endif

    assign do_wr_s  = bus.wr_en && wr_ok_r;
    assign do_rd_s  = bus.rd_en && rd_ok_r;
    assign retire_s = do_rd_s && rd_last_r;

    // Next state; outputs are precomputed for the following cycle so every port is a flop
    always_comb begin
        wr_ptr_n_s = do_wr_s  ? wr_ptr_r + AW'(1) : wr_ptr_r;
        rd_ptr_n_s = retire_s ? rd_ptr_r + AW'(1) : rd_ptr_r;
        count_n_s  = count_r + CW'(do_wr_s) - CW'(retire_s);
        usedw_n_s  = usedw_r + (do_wr_s ? UW'(wr_eff_s) : {UW{1'b0}}) - UW'(do_rd_s);
        if (retire_s) begin
            lane_n_s = {LW{1'b0}};
        end else if (do_rd_s) begin
            lane_n_s = lane_r + LW'(1);
        end else begin
            lane_n_s = lane_r;
        end
        // A word written this cycle can only be the next head when it lands at the new read pointer
        nxt_word_s  = (do_wr_s && wr_ptr_r == rd_ptr_n_s) ? bus.wr_data : mem[rd_ptr_n_s];
`ifdef RATIO_FIFO_PARTIAL_EN
        nxt_lanes_s = (do_wr_s && wr_ptr_r == rd_ptr_n_s) ? wr_eff_s : lanes_mem[rd_ptr_n_s];
`else
        nxt_lanes_s = LW'(RATIO);
`endif
        rd_data_n_s = {ODW{1'b0}};
        for (int k = 0; k < RATIO; k++) begin
            rd_data_n_s = (lane_n_s == LW'(k)) ? nxt_word_s[k*ODW +: ODW] : rd_data_n_s;
        end
    end

    // Word store; contents are not reset, occupancy tracking makes stale data unreachable
    always_ff @(posedge clk) begin
        if (rst && do_wr_s) begin
            mem[wr_ptr_r] <= bus.wr_data;
        end
    end

    // Pointers, counters and registered outputs
    always_ff @(posedge clk) begin
        if (!rst) begin
            wr_ptr_r  <= {AW{1'b0}};
            rd_ptr_r  <= {AW{1'b0}};
            count_r   <= {CW{1'b0}};
            lane_r    <= {LW{1'b0}};
            usedw_r   <= {UW{1'b0}};
            wr_ok_r   <= 1'b1;
            rd_ok_r   <= 1'b0;
            rd_last_r <= 1'b0;
            rd_data_r <= {ODW{1'b0}};
        end else begin
            wr_ptr_r  <= wr_ptr_n_s;
            rd_ptr_r  <= rd_ptr_n_s;
            count_r   <= count_n_s;
            lane_r    <= lane_n_s;
            usedw_r   <= usedw_n_s;
            wr_ok_r   <= (count_n_s != CW'(DEPTH));
            rd_ok_r   <= (count_n_s != {CW{1'b0}});
            rd_last_r <= (count_n_s != {CW{1'b0}}) && (lane_n_s == nxt_lanes_s - LW'(1));
            rd_data_r <= rd_data_n_s;
        end
    end

    assign bus.wr_ok   = wr_ok_r;
    assign bus.rd_ok   = rd_ok_r;
    assign bus.rd_last = rd_last_r;
    assign bus.usedw   = usedw_r;
    assign bus.rd_data = rd_data_r;
endmodule

// File: tb/tb_ratio_fifo.sv
// Self-checking bench for ratio_fifo: directed scenarios then random traffic against a lane-queue model.
module tb_ratio_fifo;
    localparam int ODW   = 8;
    localparam int RATIO = 4;
    localparam int DEPTH = 4;

    typedef struct {
        logic [7:0] d;
        bit         last;
    } lane_t;

    logic  clk = 1'b0;
    logic  rst = 1'b0;
    lane_t q[$];
    int    words = 0;
    int    tests = 0;
    int    fails = 0;

    always #5 clk = ~clk;

    ratio_fifo_if #(.ODW(ODW), .RATIO(RATIO), .DEPTH(DEPTH)) bus ();

    ratio_fifo #(.ODW(ODW), .RATIO(RATIO), .DEPTH(DEPTH), .ID(7)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    function automatic int eff(input int l);
`ifdef RATIO_FIFO_PARTIAL_EN
        return (l == 0 || l > RATIO) ? RATIO : l;
`else
        return RATIO;
`endif
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        assert (got === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic step(input bit r, input bit we, input logic [31:0] wd,
                        input logic [2:0] wl, input bit re, input bit chk);
        lane_t h;
        int    n;
        bit    ok_w, ok_r;
        @(negedge clk);
        rst          = r;
        bus.wr_en    = we;
        bus.wr_data  = wd;
        bus.wr_lanes = wl;
        bus.rd_en    = re;
        if (chk) begin
            check("wr_ok", 32'(bus.wr_ok), 32'(words < DEPTH));
            check("rd_ok", 32'(bus.rd_ok), 32'(words > 0));
            check("usedw", 32'(bus.usedw), 32'(q.size()));
            check("rd_last", 32'(bus.rd_last), (words > 0) ? 32'(q[0].last) : 32'd0);
            if (words > 0) check("rd_data", 32'(bus.rd_data), 32'(q[0].d));
        end
        @(posedge clk);
        if (!r) begin
            q.delete();
            words = 0;
        end else begin
            ok_w = (words < DEPTH);
            ok_r = (words > 0);
            if (re && ok_r) begin
                h = q.pop_front();
                if (h.last) words--;
            end
            if (we && ok_w) begin
                n = eff(int'(wl));
                for (int i = 0; i < n; i++) q.push_back('{wd[i*8 +: 8], (i == n - 1)});
                words++;
            end
        end
    endtask

    task automatic idle();
        step(1'b1, 1'b0, 32'h0, 3'd0, 1'b0, 1'b1);
    endtask

    task automatic wr(input logic [31:0] wd, input logic [2:0] wl);
        step(1'b1, 1'b1, wd, wl, 1'b0, 1'b1);
    endtask

    task automatic rd(input int n);
        for (int i = 0; i < n; i++) step(1'b1, 1'b0, 32'h0, 3'd0, 1'b1, 1'b1);
    endtask

    initial begin
        bus.wr_en = 1'b0; bus.wr_data = '0; bus.wr_lanes = '0; bus.rd_en = 1'b0;
        step(1'b0, 1'b0, 32'h0, 3'd0, 1'b0, 1'b0);
        step(1'b0, 1'b1, 32'hDEADBEEF, 3'd4, 1'b1, 1'b0);
        idle();
        // Full word drained lane by lane
        wr(32'h44332211, 3'd4);
        rd(5);
        // Partial word
        wr(32'hDDCCBBAA, 3'd2);
        rd(3);
        // Fill to capacity, dropped fifth write, then retire one word
        wr(32'h04030201, 3'd4);
        wr(32'h14131211, 3'd4);
        wr(32'h24232221, 3'd4);
        wr(32'h34333231, 3'd4);
        wr(32'h99999999, 3'd4);
        rd(4);
        wr(32'h44434241, 3'd4);
        idle();
        rd(16);
        idle();
        // Concurrent write and pop with one word stored and lane_q=1
        wr(32'h54535251, 3'd4);
        rd(1);
        step(1'b1, 1'b1, 32'h64636261, 3'd4, 1'b1, 1'b1);
        rd(8);
        // Out-of-range lane counts normalise to RATIO
        wr(32'h74737271, 3'd0);
        wr(32'h84838281, 3'd6);
        wr(32'h94939291, 3'd1);
        rd(10);
        // Reset mid-operation with concurrent write
        wr(32'hA4A3A2A1, 3'd4);
        wr(32'hB4B3B2B1, 3'd3);
        wr(32'hC4C3C2C1, 3'd4);
        rd(2);
        step(1'b0, 1'b1, 32'hEEEEEEEE, 3'd4, 1'b1, 1'b1);
        idle();
        idle();
        // Random traffic
        for (int i = 0; i < 600; i++) begin
            step(($urandom_range(0, 79) != 0), ($urandom_range(0, 2) != 0), $urandom,
                 3'($urandom_range(0, 7)), ($urandom_range(0, 3) != 0), 1'b1);
        end
        rd(20);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
